// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared op encodings and FSM states for the chunked add/sub unit
package alsu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEGB = 2'b10,
    OP_NEGA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/chunk_ripple_adder.sv
// rtl/chunk_ripple_adder.sv - CHUNK-bit combinational ripple adder slice
module chunk_ripple_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [CHUNK-1:0] i_y,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_s[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
      w_c[i+1] = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
    end
    o_cout = w_c[CHUNK];
  end

endmodule

// File: rtl/chunked_addsub_unit.sv
// rtl/chunked_addsub_unit.sv - multi-cycle add/sub/negate unit, one CHUNK slice per clock
module chunked_addsub_unit
  import alsu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             negative
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("chunked_addsub_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  op_e              r_op;
  logic             r_carry_out;
  logic             r_negative;

  int               w_lsb;
  logic             w_last;
  logic [CHUNK-1:0] w_ax;
  logic [CHUNK-1:0] w_ay;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;

  // The single slice is shared: RUN feeds X/Y, NEG feeds ~result with Y=0.
  always_comb begin
    w_lsb  = int'(r_cnt) * CHUNK;
    w_last = (r_cnt == LAST);
    w_ax   = '0;
    w_ay   = '0;
    if (r_state == NEG) begin
      w_ax = ~r_res[w_lsb +: CHUNK];
    end else begin
      w_ax = r_x[w_lsb +: CHUNK];
      w_ay = r_y[w_lsb +: CHUNK];
    end
  end

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .i_x    (w_ax),
    .i_y    (w_ay),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (w_last) w_next = ((r_op == OP_SUB) && !w_cout) ? NEG : DONE;
      NEG:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    sum       = r_res;
    carry_out = r_carry_out;
    negative  = r_negative;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_res       <= '0;
      r_op        <= OP_ADD;
      r_carry_out <= 1'b0;
      r_negative  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt       <= '0;
            r_op        <= op_e'(op);
            r_carry_out <= 1'b0;
            r_negative  <= 1'b0;
            case (op_e'(op))
              OP_ADD:  begin r_x <= a;   r_y <= b;   r_carry <= 1'b0; end
              OP_SUB:  begin r_x <= a;   r_y <= ~b;  r_carry <= 1'b1; end
              OP_NEGB: begin r_x <= '0;  r_y <= ~b;  r_carry <= 1'b1; end
              default: begin r_x <= ~a;  r_y <= '0;  r_carry <= 1'b1; end
            endcase
          end
        end
        RUN, NEG: begin
          r_res[w_lsb +: CHUNK] <= w_s;
          r_carry               <= w_cout;
          r_cnt                 <= w_last ? '0 : r_cnt + 1'b1;
          if ((r_state == RUN) && w_last) begin
            if (r_op == OP_ADD) r_carry_out <= w_cout;
            // A missing carry on SUB is a borrow: rerun as a negate pass.
            if ((r_op == OP_SUB) && !w_cout) begin
              r_carry    <= 1'b1;
              r_negative <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// tb/tb_chunked_addsub_unit.sv - self-checking bench for chunked_addsub_unit (8/2, 8/8, 12/3)
module tb_chunked_addsub_unit;
  import alsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv[3];
  logic        ordy[3];
  logic [11:0] av[3];
  logic [11:0] bv[3];
  logic [1:0]  opv[3];

  logic        ir_w[3];
  logic        ov_w[3];
  logic [11:0] s_w[3];
  logic        co_w[3];
  logic        ng_w[3];

  logic [7:0]  s0, s1;
  logic [11:0] s2;

  int W_OF[3] = '{8, 8, 12};
  int N_OF[3] = '{4, 1, 4};

  chunked_addsub_unit #(.WIDTH(8), .CHUNK(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_w[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .op(opv[0]),
    .out_valid(ov_w[0]), .out_ready(ordy[0]), .sum(s0),
    .carry_out(co_w[0]), .negative(ng_w[0]));

  chunked_addsub_unit #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_w[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .op(opv[1]),
    .out_valid(ov_w[1]), .out_ready(ordy[1]), .sum(s1),
    .carry_out(co_w[1]), .negative(ng_w[1]));

  chunked_addsub_unit #(.WIDTH(12), .CHUNK(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir_w[2]),
    .a(av[2]), .b(bv[2]), .op(opv[2]),
    .out_valid(ov_w[2]), .out_ready(ordy[2]), .sum(s2),
    .carry_out(co_w[2]), .negative(ng_w[2]));

  assign s_w[0] = {4'b0, s0};
  assign s_w[1] = {4'b0, s1};
  assign s_w[2] = s2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  task automatic model(input int w, input logic [1:0] op, input logic [11:0] a, input logic [11:0] b,
                       output logic [11:0] s, output logic c, output logic n, output logic borrow);
    int mask, ai, bi, t;
    mask = (1 << w) - 1;
    ai = int'(a) & mask;
    bi = int'(b) & mask;
    c = 1'b0; n = 1'b0; borrow = 1'b0;
    case (op)
      2'd0: begin t = ai + bi; s = 12'(t & mask); c = ((t >> w) != 0); end
      2'd1: begin
        if (ai >= bi) s = 12'(ai - bi);
        else begin s = 12'(bi - ai); n = 1'b1; borrow = 1'b1; end
      end
      2'd2: s = 12'((0 - bi) & mask);
      default: s = 12'((0 - ai) & mask);
    endcase
  endtask

  task automatic issue(input int d, input logic [1:0] op, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    check($sformatf("in_ready_before_issue[%0d]", d), 32'(ir_w[d]), 32'd1);
    iv[d] = 1'b1; opv[d] = op; av[d] = a; bv[d] = b;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    av[d] = 12'($urandom); bv[d] = 12'($urandom); opv[d] = 2'($urandom);
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!ov_w[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input int d);
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    check($sformatf("in_ready_after_handshake[%0d]", d), 32'(ir_w[d]), 32'd1);
    check($sformatf("out_valid_after_handshake[%0d]", d), 32'(ov_w[d]), 32'd0);
  endtask

  task automatic run_and_check(input string tag, input int d, input logic [1:0] op,
                               input logic [11:0] a, input logic [11:0] b,
                               input logic [11:0] es, input logic ec, input logic en, input int elat);
    int lat;
    issue(d, op, a, b);
    wait_done(d, lat);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".sum"}, 32'(s_w[d]), 32'(es));
    check({tag, ".carry_out"}, 32'(co_w[d]), 32'(ec));
    check({tag, ".negative"}, 32'(ng_w[d]), 32'(en));
    release_out(d);
  endtask

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       n;
    int         lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat;
    logic [11:0] ms;
    logic mc, mn, mb;
    logic [1:0] rop;
    logic [11:0] ra, rb;

    vt[0] = '{OP_ADD,  8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 4};
    vt[1] = '{OP_SUB,  8'd5,   8'd9,   8'd4,  1'b0, 1'b1, 8};
    vt[2] = '{OP_SUB,  8'd9,   8'd9,   8'd0,  1'b0, 1'b0, 4};
    vt[3] = '{OP_NEGB, 8'h55,  8'd1,   8'hFF, 1'b0, 1'b0, 4};
    vt[4] = '{OP_NEGA, 8'd0,   8'hAA,  8'h00, 1'b0, 1'b0, 4};
    vt[5] = '{OP_SUB,  8'd0,   8'd255, 8'hFF, 1'b0, 1'b1, 8};
    vt[6] = '{OP_ADD,  8'd255, 8'd255, 8'hFE, 1'b1, 1'b0, 4};
    vt[7] = '{OP_NEGA, 8'd1,   8'h00,  8'hFF, 1'b0, 1'b0, 4};
    vt[8] = '{OP_SUB,  8'd200, 8'd3,   8'd197, 1'b0, 1'b0, 4};

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0; opv[d] = 2'd0;
    end
    rst = 1'b1;
    #12;
    check("reset.in_ready", 32'(ir_w[0]), 32'd1);
    check("reset.out_valid", 32'(ov_w[0]), 32'd0);
    check("reset.sum", 32'(s_w[0]), 32'd0);
    check("reset.carry_out", 32'(co_w[0]), 32'd0);
    check("reset.negative", 32'(ng_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_and_check($sformatf("vec%0d", i), 0, vt[i].op, {4'b0, vt[i].a}, {4'b0, vt[i].b},
                    {4'b0, vt[i].s}, vt[i].c, vt[i].n, vt[i].lat);

    // Backpressure: results hold, new operands are ignored.
    issue(0, OP_ADD, 12'd17, 12'd3);
    wait_done(0, lat);
    check("bp.latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iv[0] = 1'b1; opv[0] = OP_SUB; av[0] = 12'(k + 1); bv[0] = 12'd99;
      @(posedge clk); #1;
      check("bp.sum", 32'(s_w[0]), 32'd20);
      check("bp.flags", {30'd0, co_w[0], ng_w[0]}, 32'd0);
      check("bp.out_valid", 32'(ov_w[0]), 32'd1);
      check("bp.in_ready", 32'(ir_w[0]), 32'd0);
    end
    iv[0] = 1'b0;
    release_out(0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp.not_taken", {30'd0, ov_w[0], ir_w[0]}, 32'd1);
    end

    // Asynchronous reset in the middle of the NEG pass.
    issue(0, OP_SUB, 12'd3, 12'd200);
    repeat (6) @(posedge clk);
    #2;
    check("pre_rst.negative", 32'(ng_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst.in_ready", 32'(ir_w[0]), 32'd1);
    check("async_rst.out_valid", 32'(ov_w[0]), 32'd0);
    check("async_rst.sum", 32'(s_w[0]), 32'd0);
    check("async_rst.flags", {30'd0, co_w[0], ng_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("post_rst_add", 0, OP_ADD, 12'd1, 12'd1, 12'd2, 1'b0, 1'b0, 4);

    // Single-slice configuration.
    run_and_check("c8_add", 1, OP_ADD, 12'd255, 12'd1, 12'd0, 1'b1, 1'b0, 1);
    run_and_check("c8_sub", 1, OP_SUB, 12'd5, 12'd9, 12'd4, 1'b0, 1'b1, 2);
    run_and_check("c8_nega", 1, OP_NEGA, 12'd0, 12'd7, 12'd0, 1'b0, 1'b0, 1);

    // Randomized sweep on the 12/3 instance.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 12'($urandom);
      rb  = (i % 8 == 0) ? ra : 12'($urandom);
      model(W_OF[2], rop, ra, rb, ms, mc, mn, mb);
      run_and_check($sformatf("rnd%0d", i), 2, rop, ra, rb, ms, mc, mn,
                    mb ? 2 * N_OF[2] : N_OF[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
